// File: rtl/nroot_int_fp_pkg.sv
// Shared definitions for the integer-index n-th root unit: default format, FSM states, special-case classes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nroot_pkg;

  // Default operand format (IEEE-754 binary32) and largest supported index
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_N_W   = 4;
  localparam int DEF_MAX_N = 8;

  localparam int BIAS  = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int FP_W  = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int RAD_W = (DEF_MAN_W + 1) * DEF_MAX_N;

  localparam logic [FP_W-1:0] QNAN = {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};
  localparam logic [FP_W-1:0] PINF = {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, SETUP, POW, CMP, PACK} state_e;

  typedef enum logic [2:0] {
    CLS_NAN_INV,  // generated NaN, invalid flag raised
    CLS_NAN,      // NaN operand propagated as canonical qNaN
    CLS_ZERO,     // signed zero (including flushed denormals)
    CLS_PINF,
    CLS_NINF,
    CLS_PASS,     // N=1: operand returned unchanged
    CLS_NORMAL    // needs the digit-by-digit loop
  } cls_e;

  // Ordered special-case decision; earlier checks take priority
  function automatic cls_e classify(input logic n_bad, input logic is_nan, input logic is_zero,
                                    input logic is_inf, input logic sign, input logic n_odd,
                                    input logic n_one);
    cls_e c;
    if (n_bad)              c = CLS_NAN_INV;
    else if (is_nan)        c = CLS_NAN;
    else if (is_zero)       c = CLS_ZERO;
    else if (is_inf)        c = sign ? (n_odd ? CLS_NINF : CLS_NAN_INV) : CLS_PINF;
    else if (sign && !n_odd) c = CLS_NAN_INV;
    else if (n_one)         c = CLS_PASS;
    else                    c = CLS_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/nroot_floor_div.sv
// Signed floor division of an unbiased exponent by a small unsigned index: q=floor(e/n), 0<=r<n.
// Latency: combinational.
// Backpressure: not applicable; caller must keep i_n nonzero.
module nroot_floor_div #(
  parameter int E_W = 9,
  parameter int N_W = 4
) (
  input  logic [E_W-1:0] i_e,
  input  logic [N_W-1:0] i_n,
  output logic [E_W-1:0] o_q,
  output logic [N_W-1:0] o_r
);

  localparam int D_W = ((E_W > N_W) ? E_W : N_W) + 1;

  logic signed [D_W-1:0] w_e;
  logic signed [D_W-1:0] w_n;
  logic signed [D_W-1:0] w_q0;
  logic signed [D_W-1:0] w_r0;
  logic signed [D_W-1:0] w_q;
  logic signed [D_W-1:0] w_r;
  logic                  w_unused;

  assign w_e  = {{(D_W-E_W){i_e[E_W-1]}}, i_e};
  assign w_n  = {{(D_W-N_W){1'b0}}, i_n};
  assign w_q0 = w_e / w_n;
  assign w_r0 = w_e % w_n;

  // Truncating division rounds toward zero; pull negative remainders back into [0, n)
  always_comb begin
    w_q = w_q0;
    w_r = w_r0;
    if (w_r0[D_W-1]) begin
      w_q = w_q0 - D_W'(1);
      w_r = w_r0 + w_n;
    end
  end

  assign o_q      = w_q[E_W-1:0];
  assign o_r      = w_r[N_W-1:0];
  assign w_unused = ^{w_q[D_W-1:E_W], w_r[D_W-1:N_W]};

endmodule

// File: rtl/nroot_int_fp.sv
// Integer-index n-th root of a float, truncating, one result bit per N cycles on a shared multiplier.
// Latency: 2 edges for special cases and N=1, 2+MAN_W*N edges otherwise.
// Backpressure: start is only honoured while idle (busy=0); requests during busy are dropped.
module nroot_int_fp
  import nroot_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int N_W   = DEF_N_W,
  parameter int MAX_N = DEF_MAX_N
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [N_W-1:0]         N,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int W_FP   = 1 + EXP_W + MAN_W;
  localparam int W_RAD  = (MAN_W + 1) * MAX_N;
  localparam int W_E    = EXP_W + 1;
  localparam int W_K    = $clog2(MAN_W);
  localparam int W_BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [W_FP-1:0] L_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W_FP-1:0] L_PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  state_e            r_state;
  state_e            w_nstate;
  logic [W_FP-1:0]   r_a;
  logic [N_W-1:0]    r_n;
  logic              r_sign;
  logic [W_E-1:0]    r_q;
  logic [W_RAD-1:0]  r_rad;
  logic              r_special;
  logic [W_FP-1:0]   r_spec_res;
  logic              r_uf_pend;
  logic              r_inv_pend;
  logic [MAN_W:0]    r_y;
  logic [W_K-1:0]    r_k;
  logic [W_RAD-1:0]  r_p;
  logic [N_W-1:0]    r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [W_FP-1:0]   r_result;
  logic              r_uf;
  logic              r_inv;

  logic              w_accept;
  logic              w_do_setup;
  logic              w_do_pow;
  logic              w_do_cmp;
  logic              w_do_pack;

  // Operand unpack and classification (meaningful while in SETUP)
  logic              w_s;
  logic [EXP_W-1:0]  w_e;
  logic [MAN_W-1:0]  w_f;
  logic              w_is_den;
  logic              w_is_zero;
  logic              w_is_inf;
  logic              w_is_nan;
  logic              w_n_bad;
  cls_e              w_cls;
  logic [W_FP-1:0]   w_spec_res;

  assign w_s       = r_a[W_FP-1];
  assign w_e       = r_a[W_FP-2:MAN_W];
  assign w_f       = r_a[MAN_W-1:0];
  assign w_is_zero = (w_e == '0);
  assign w_is_den  = w_is_zero && (w_f != '0);
  assign w_is_inf  = (&w_e) && (w_f == '0);
  assign w_is_nan  = (&w_e) && (w_f != '0);
  assign w_n_bad   = (r_n == '0) || (32'(r_n) > MAX_N);
  assign w_cls     = classify(w_n_bad, w_is_nan, w_is_zero, w_is_inf, w_s, r_n[0], r_n == N_W'(1));

  // Result for every non-loop class; denormals already count as zero here
  always_comb begin
    w_spec_res = '0;
    case (w_cls)
      CLS_NAN_INV, CLS_NAN: w_spec_res = L_QNAN;
      CLS_ZERO:             w_spec_res = {w_s, {(W_FP-1){1'b0}}};
      CLS_PINF:             w_spec_res = L_PINF;
      CLS_NINF:             w_spec_res = {1'b1, L_PINF[W_FP-2:0]};
      CLS_PASS:             w_spec_res = r_a;
      default:              w_spec_res = '0;
    endcase
  end

  // Exponent split: E = q*N + r, the remainder is folded into the radicand
  logic [W_E-1:0]    w_e_unb;
  logic [N_W-1:0]    w_div_n;
  logic [W_E-1:0]    w_q;
  logic [N_W-1:0]    w_r;
  logic [31:0]       w_rad_sh;
  logic [W_RAD-1:0]  w_rad;

  assign w_e_unb  = W_E'({1'b0, w_e}) - W_E'(W_BIAS);
  assign w_div_n  = w_n_bad ? N_W'(1) : r_n;
  assign w_rad_sh = 32'(w_r) + 32'(MAN_W) * (32'(w_div_n) - 32'd1);
  assign w_rad    = W_RAD'({1'b1, w_f}) << w_rad_sh;

  nroot_floor_div #(
    .E_W (W_E),
    .N_W (N_W)
  ) u_floor_div (
    .i_e (w_e_unb),
    .i_n (w_div_n),
    .o_q (w_q),
    .o_r (w_r)
  );

  // Trial root, shared multiplier and compare
  logic [MAN_W:0]    w_t;
  logic [MAN_W:0]    w_y_new;
  logic [MAN_W:0]    w_bit_nx;
  logic [W_RAD-1:0]  w_prod;
  logic [W_E-1:0]    w_exp_out;
  logic              w_unused;

  assign w_t       = r_y | ({{MAN_W{1'b0}}, 1'b1} << r_k);
  assign w_prod    = r_p * W_RAD'(w_t);
  assign w_y_new   = (r_p <= r_rad) ? w_t : r_y;
  assign w_bit_nx  = {{MAN_W{1'b0}}, 1'b1} << (r_k - 1'b1);
  assign w_exp_out = r_q + W_E'(W_BIAS);
  assign w_unused  = w_exp_out[W_E-1];

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nstate;
  end

  // Next-state: each result bit is N-1 POW cycles plus one CMP cycle
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (start) w_nstate = SETUP;
      SETUP:   w_nstate = (w_cls == CLS_NORMAL) ? POW : PACK;
      POW:     if (r_cnt + N_W'(1) == r_n) w_nstate = CMP;
      CMP:     w_nstate = (r_k == '0) ? PACK : POW;
      PACK:    w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_accept   = (r_state == IDLE) && start;
    w_do_setup = (r_state == SETUP);
    w_do_pow   = (r_state == POW);
    w_do_cmp   = (r_state == CMP);
    w_do_pack  = (r_state == PACK);
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_a        <= '0;
      r_n        <= '0;
      r_sign     <= 1'b0;
      r_q        <= '0;
      r_rad      <= '0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_uf_pend  <= 1'b0;
      r_inv_pend <= 1'b0;
      r_y        <= '0;
      r_k        <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_uf       <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a    <= A;
        r_n    <= N;
        r_busy <= 1'b1;
        r_uf   <= 1'b0;
        r_inv  <= 1'b0;
      end
      if (w_do_setup) begin
        r_sign     <= w_s;
        r_q        <= w_q;
        r_rad      <= w_rad;
        r_special  <= (w_cls != CLS_NORMAL);
        r_spec_res <= w_spec_res;
        r_uf_pend  <= w_is_den;
        r_inv_pend <= (w_cls == CLS_NAN_INV);
        r_y        <= {1'b1, {MAN_W{1'b0}}};
        r_k        <= W_K'(MAN_W - 1);
        r_p        <= W_RAD'({2'b11, {(MAN_W-1){1'b0}}});
        r_cnt      <= N_W'(1);
      end
      if (w_do_pow) begin
        r_p   <= w_prod;
        r_cnt <= r_cnt + N_W'(1);
      end
      if (w_do_cmp) begin
        r_y   <= w_y_new;
        r_cnt <= N_W'(1);
        if (r_k != '0) begin
          r_k <= r_k - 1'b1;
          r_p <= W_RAD'(w_y_new | w_bit_nx);
        end
      end
      if (w_do_pack) begin
        r_result <= r_special ? r_spec_res : {r_sign, w_exp_out[EXP_W-1:0], r_y[MAN_W-1:0]};
        r_uf     <= r_uf_pend;
        r_inv    <= r_inv_pend;
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign overflow  = 1'b0;
  assign underflow = r_uf;
  assign invalid   = r_inv;

endmodule

// File: tb/tb_nroot_int_fp.sv
// Scoreboard bench for nroot_int_fp: directed specials, exact roots, truncation, abort, random sweep.
// Latency: checks done timing against 2 or 2+23*N edges.
// Backpressure: checks that start pulses while busy are ignored.
module tb_nroot_int_fp;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [3:0]  N = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  nroot_int_fp dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .A         (A),
    .N         (N),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        uf;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] pw(input logic [255:0] y, input int n);
    logic [255:0] p;
    p = 256'd1;
    for (int i = 0; i < n; i++) p = p * y;
    return p;
  endfunction

  // Truncating reference: real-valued estimate refined against exact integer powers
  function automatic exp_t model(input logic [31:0] a, input int n);
    exp_t         x;
    logic         s;
    logic [7:0]   ex;
    logic [22:0]  f;
    int           e_unb, q, r;
    logic [255:0] rad, y;
    real          v;
    x.uf = 1'b0; x.inv = 1'b0; x.lat = 2;
    s = a[31]; ex = a[30:23]; f = a[22:0];
    if (ex == 8'h00 && f != 0) begin x.uf = 1'b1; f = '0; end
    if (n == 0 || n > 8) begin x.res = 32'h7FC00000; x.inv = 1'b1; end
    else if (ex == 8'hFF && f != 0) x.res = 32'h7FC00000;
    else if (ex == 8'h00) x.res = {s, 31'b0};
    else if (ex == 8'hFF) begin
      if (!s) x.res = 32'h7F800000;
      else if (n % 2 == 1) x.res = 32'hFF800000;
      else begin x.res = 32'h7FC00000; x.inv = 1'b1; end
    end
    else if (s && n % 2 == 0) begin x.res = 32'h7FC00000; x.inv = 1'b1; end
    else if (n == 1) x.res = a;
    else begin
      e_unb = int'(ex) - 127;
      if (e_unb >= 0) q = e_unb / n;
      else q = -((-e_unb + n - 1) / n);
      r = e_unb - q * n;
      rad = 256'({1'b1, f}) << (r + 23 * (n - 1));
      v = real'({1'b1, f}) / 8388608.0;
      for (int i = 0; i < r; i++) v = v * 2.0;
      v = $pow(v, 1.0 / real'(n));
      y = 256'($rtoi(v * 8388608.0));
      while (pw(y + 256'd1, n) <= rad) y = y + 256'd1;
      while (pw(y, n) > rad) y = y - 256'd1;
      x.res = {s, 8'(q + 127), y[22:0]};
      x.lat = 2 + 23 * n;
    end
    return x;
  endfunction

  task automatic run_op(input logic [31:0] a, input int n, input bit poke);
    logic [31:0] prev;
    int          lat;
    bit          seen, busy_ok, hold_ok;
    exp_t        x;
    @(negedge CLK);
    prev = result;
    A = a; N = n[3:0]; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0; seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!seen && lat < 400) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 1) chk($sformatf("flags_clr a=%h n=%0d", a, n), {30'b0, underflow, invalid}, 32'd0);
      if (done) seen = 1'b1;
      else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (result !== prev) hold_ok = 1'b0;
        if (poke) begin A = $urandom; N = 4'($urandom_range(0, 15)); start = 1'b1; end
      end
    end
    start = 1'b0;
    chk($sformatf("done_seen a=%h n=%0d", a, n), 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      chk($sformatf("latency a=%h n=%0d", a, n), 32'(lat), 32'(x.lat));
      chk($sformatf("result a=%h n=%0d", a, n), result, x.res);
      chk($sformatf("underflow a=%h n=%0d", a, n), 32'(underflow), 32'(x.uf));
      chk($sformatf("invalid a=%h n=%0d", a, n), 32'(invalid), 32'(x.inv));
    end
    chk($sformatf("overflow a=%h n=%0d", a, n), 32'(overflow), 32'd0);
    chk($sformatf("busy_during a=%h n=%0d", a, n), 32'(busy_ok), 32'd1);
    chk($sformatf("result_hold a=%h n=%0d", a, n), 32'(hold_ok), 32'd1);
    chk($sformatf("busy_at_done a=%h n=%0d", a, n), 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk($sformatf("done_pulse a=%h n=%0d", a, n), 32'(done), 32'd0);
  endtask

  task automatic dir(input logic [31:0] a, input int n, input logic [31:0] res,
                     input logic uf, input logic inv, input int lat, input bit poke);
    exp_t x;
    x.res = res; x.uf = uf; x.inv = inv; x.lat = lat;
    sb.push_back(x);
    run_op(a, n, poke);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        x;
    logic [31:0] a;
    int          n;
    logic        s;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, overflow, underflow, invalid}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Directed: exact roots, negative-exponent floor, truncation, specials
    dir(32'h41D80000, 3, 32'h40400000, 1'b0, 1'b0, 71, 1'b1);
    dir(32'hC1000000, 3, 32'hC0000000, 1'b0, 1'b0, 71, 1'b0);
    dir(32'h3E800000, 2, 32'h3F000000, 1'b0, 1'b0, 48, 1'b0);
    dir(32'h40000000, 2, 32'h3FB504F3, 1'b0, 1'b0, 48, 1'b0);
    dir(32'hC0800000, 2, 32'h7FC00000, 1'b0, 1'b1, 2, 1'b0);
    dir(32'h7F800000, 5, 32'h7F800000, 1'b0, 1'b0, 2, 1'b0);
    dir(32'h00000000, 4, 32'h00000000, 1'b0, 1'b0, 2, 1'b0);
    dir(32'h3F800000, 0, 32'h7FC00000, 1'b0, 1'b1, 2, 1'b1);
    dir(32'h00000001, 2, 32'h00000000, 1'b1, 1'b0, 2, 1'b0);
    dir(32'h41D80000, 1, 32'h41D80000, 1'b0, 1'b0, 2, 1'b0);
    dir(32'h40000000, 9, 32'h7FC00000, 1'b0, 1'b1, 2, 1'b0);
    dir(32'hFF800000, 3, 32'hFF800000, 1'b0, 1'b0, 2, 1'b0);
    dir(32'hFF800000, 4, 32'h7FC00000, 1'b0, 1'b1, 2, 1'b0);
    dir(32'h7FC12345, 2, 32'h7FC00000, 1'b0, 1'b0, 2, 1'b0);
    dir(32'h80000000, 2, 32'h80000000, 1'b0, 1'b0, 2, 1'b0);

    // Abort mid-loop: outputs clear on the next edge, then a fresh op works
    @(negedge CLK);
    A = 32'h41D80000; N = 4'd3; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {29'b0, overflow, underflow, invalid}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    dir(32'h41D80000, 3, 32'h40400000, 1'b0, 1'b0, 71, 1'b0);

    // Random sweep against the truncating reference
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, 8);
      s = (n % 2 == 1) && ($urandom_range(0, 3) == 0);
      a = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      x = model(a, n);
      sb.push_back(x);
      run_op(a, n, (i % 7) == 0);
    end

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nroot_int_fp.md
Name: nroot_int_fp

Overview:
- Parametrised, multi-cycle IEEE-754 integer-index n-th root unit for the FP calculator: result = A^(1/N), with A a floating-point operand and N an unsigned integer index.
- Successor to the fixed-format float32 nroot. Adds format parameters, a start/busy/done handshake, odd-index roots of negative operands, and an invalid flag.
- Uses digit-by-digit root extraction with a single sequential multiplier. Rounding is toward zero (truncate).

Parameters:
- EXP_W, 8, exponent width. FP_W = 1+EXP_W+MAN_W.
- MAN_W, 23, stored fraction width.
- N_W, 4, width of index port N.
- MAX_N, 8, largest supported index. N>MAX_N is treated as invalid. Sets radicand width RAD_W = (MAN_W+1)*MAX_N.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: synchronous, active-low reset.
- start in 1: request. Sampled only in IDLE.
- A in FP_W: operand. Captured when start is accepted.
- N in N_W: root index. Captured when start is accepted.
- busy out 1: high from the cycle after accept until done.
- done out 1: one-cycle pulse when result is valid.
- result out FP_W: held until the next done.
- overflow out 1: always 0 for this operation; kept for calculator interface uniformity.
- underflow out 1: 1 when a denormal A was flushed to zero.
- invalid out 1: 1 when result is a generated NaN.

Behaviour:
- Reset (RST=0 at an edge): state IDLE; busy, done, result, overflow, underflow, invalid all 0. Reset aborts any operation in flight.
- FSM: IDLE -> SETUP -> (POW <-> CMP)* -> PACK -> IDLE. SETUP jumps straight to PACK for special cases.
- IDLE: on start=1, latch A and N and go to SETUP. start in any other state is ignored.
- SETUP: unpack sign s, exponent e, fraction f. Denormal A becomes signed zero with underflow=1. Special cases, first match wins:
  - N=0 or N>MAX_N -> canonical qNaN {0, all-ones exponent, fraction MSB 1}, invalid=1.
  - A NaN -> canonical qNaN, invalid=0.
  - A=±0 -> A.
  - A=+Inf -> +Inf.
  - A=-Inf -> -Inf if N is odd; otherwise qNaN with invalid=1.
  - A finite negative with N even -> qNaN, invalid=1.
  - N=1 -> A unchanged.
- Normal path:
  - E = e-BIAS (signed). q = floor(E/N). r = E-q*N, with 0<=r<N; floor must hold for negative E.
  - RAD = ({1,f} << r) << (MAN_W*(N-1)), RAD_W bits.
  - Y starts at 1<<MAN_W.
- Bit loop, for k = MAN_W-1 down to 0:
  - T = Y | (1<<k).
  - POW: P = T, then N-1 cycles of P = P*T on one RAD_W x (MAN_W+1) multiplier.
  - CMP (1 cycle): if P <= RAD then Y = T.
  - Each bit costs exactly N cycles. Product bits above RAD_W cannot occur for N <= MAX_N.
- PACK: result = {s, q+BIAS, Y[MAN_W-1:0]}. Exponent never overflows or underflows, since |q| <= |E|.
- Outputs: result and flags are registered in PACK; done=1 for that single cycle. busy is 1 during SETUP, POW, CMP and PACK.
- Latency, counted in edges from the start-accept edge to the done edge:
  - special cases and N=1: 2.
  - normal: 2+MAN_W*N (float32 with N=3: 71).
- Flags are cleared at accept and valid only alongside done.

Decomposition:
- Package nroot_pkg holds:
  - FP-format localparams: BIAS, FP_W, RAD_W.
  - Canonical qNaN and Inf constants.
  - State enum {IDLE, SETUP, POW, CMP, PACK}.
  - Special-case classification function.
- One sub-module: nroot_floor_div, a combinational signed floor-divide of E by N returning q and r. Shared with future log/exp blocks.

Test Plan:
- A=0x41D80000 (27.0), N=3 -> result 0x40400000 (3.0), flags 0, done exactly 71 edges after accept, busy high throughout.
- A=0xC1000000 (-8.0), N=3 -> 0xC0000000 (-2.0). A=0x3E800000 (0.25), N=2 -> 0x3F000000 (0.5); exercises negative-exponent floor.
- A=0x40000000 (2.0), N=2 -> 0x3FB504F3, truncation check (round-to-nearest would also give F3, so also compare against a truncating reference model across random A).
- Specials, each done after 2 edges:
  - A=0xC0800000, N=2 -> 0x7FC00000 with invalid=1.
  - A=0x7F800000, N=5 -> 0x7F800000.
  - A=0x00000000, N=4 -> 0x00000000.
  - N=0 -> 0x7FC00000 with invalid=1.
  - A=0x00000001, N=2 -> 0x00000000 with underflow=1.
- Pulse start repeatedly during busy -> ignored; result unchanged until done. Drive RST=0 mid-loop -> next cycle busy=0, done=0, result=0. A new start then computes correctly.
- Random sweep with N in 1..8 and positive normal A -> result matches the truncating reference model bit-exactly.
